// File: rtl/systolic_feeder_if.sv
// Signal bundle between systolic_feeder and its environment (operand source, array, result sink).
// slave = feeder side, master = environment side.
interface systolic_feeder_if #(
   parameter int WIDTH = 8,
   parameter int DIM   = 3
);
   logic                         in_valid;
   logic                         in_ready;
   logic [DIM*WIDTH-1:0]         in_data;
   logic                         array_reset;
   logic [DIM*WIDTH-1:0]         array_left;
   logic [DIM*WIDTH-1:0]         array_top;
   logic [2*DIM*DIM*WIDTH-1:0]   array_result;
   logic                         out_valid;
   logic                         out_ready;
   logic [2*DIM*DIM*WIDTH-1:0]   out_data;
   logic                         busy;

   modport slave (
      input  in_valid, in_data, array_result, out_ready,
      output in_ready, array_reset, array_left, array_top, out_valid, out_data, busy
   );

   modport master (
      output in_valid, in_data, array_result, out_ready,
      input  in_ready, array_reset, array_left, array_top, out_valid, out_data, busy
   );
endinterface

// File: rtl/systolic_feeder.sv
// Loads A/B operand rows, drives skewed zero-padded streams into systolic_array, captures its result.
// Build option SYSTOLIC_FEEDER_B_COLMAJOR_EN: B beats carry columns instead of rows.
module systolic_feeder #(
   parameter int WIDTH        = 8,
   parameter int DIM          = 3,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic             clock,
   input  logic             reset,
   systolic_feeder_if.slave bus
);
   localparam int VW = DIM*WIDTH;
   localparam int RW = 2*DIM*DIM*WIDTH;
   localparam int IW = $clog2(DIM);
   localparam int BW = $clog2(2*DIM);
   localparam int TW = $clog2(3*DIM);
   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   localparam logic [2:0] LOAD  = 3'd0;
   localparam logic [2:0] CLEAR = 3'd1;
   localparam logic [2:0] FEED  = 3'd2;
   localparam logic [2:0] DRAIN = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   localparam logic [BW-1:0] BEAT_LAST = BW'(2*DIM-1);
   localparam logic [BW-1:0] BEAT_B    = BW'(DIM);
   localparam logic [TW-1:0] T_LAST    = TW'(3*DIM-3);
   localparam logic [DW-1:0] D_LAST    = DW'(DRAIN_CYCLES-1);

   logic [2:0]                          state_reg;
   logic [BW-1:0]                       beat_reg;
   logic [TW-1:0]                       t_reg;
   logic [DW-1:0]                       drain_reg;
   logic [VW-1:0]                       left_reg, top_reg;
   logic [VW-1:0]                       left_next, top_next;
   logic                                out_valid_reg;
   logic                                array_reset_reg;
   logic [RW-1:0]                       out_data_reg;
   logic [VW-1:0]                       a_mem [DIM];
   logic [VW-1:0]                       b_mem [DIM];
   logic [DIM-1:0][DIM-1:0][WIDTH-1:0]  a_el, b_el;
   logic [TW-1:0]                       feed_t;
   logic                                in_fire;
   logic [IW-1:0]                       a_wr_idx, b_wr_idx;

   assign in_fire  = (state_reg == LOAD) && bus.in_valid;
   assign a_wr_idx = beat_reg[IW-1:0];
   assign b_wr_idx = IW'(beat_reg - BEAT_B);

   // Beats are stored as received; the element views below decide how B is interpreted.
   always_ff @(posedge clock) begin
      if (in_fire) begin
         if (beat_reg < BEAT_B)
            a_mem[a_wr_idx] <= bus.in_data;
         else
            b_mem[b_wr_idx] <= bus.in_data;
      end
   end

   genvar gi, gj;
   generate
      for (gi = 0; gi < DIM; gi++) begin : g_row
         for (gj = 0; gj < DIM; gj++) begin : g_col
            assign a_el[gi][gj] = a_mem[gi][(DIM-1-gj)*WIDTH +: WIDTH];
`ifdef SYSTOLIC_FEEDER_B_COLMAJOR_EN
            assign b_el[gi][gj] = b_mem[gj][(DIM-1-gi)*WIDTH +: WIDTH];
`else
            assign b_el[gi][gj] = b_mem[gi][(DIM-1-gj)*WIDTH +: WIDTH];
`endif
         end
      end
   endgenerate

   // Stream values are computed for the step about to be entered, so they line up with t_reg.
   assign feed_t = (state_reg == FEED) ? t_reg + TW'(1) : '0;

   generate
      for (gi = 0; gi < DIM; gi++) begin : g_feed
         logic [TW-1:0] k_idx;
         logic          k_ok;
         assign k_idx = feed_t - TW'(gi);
         assign k_ok  = (feed_t >= TW'(gi)) && (k_idx < TW'(DIM));
         assign left_next[(DIM-1-gi)*WIDTH +: WIDTH] = k_ok ? a_el[gi][k_idx[IW-1:0]] : '0;
         assign top_next[(DIM-1-gi)*WIDTH +: WIDTH]  = k_ok ? b_el[k_idx[IW-1:0]][gi] : '0;
      end
   endgenerate

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg       <= LOAD;
         beat_reg        <= '0;
         t_reg           <= '0;
         drain_reg       <= '0;
         left_reg        <= '0;
         top_reg         <= '0;
         out_valid_reg   <= 1'b0;
         out_data_reg    <= '0;
         array_reset_reg <= 1'b0;
      end else begin
         array_reset_reg <= 1'b1;
         left_reg        <= '0;
         top_reg         <= '0;
         case (state_reg)
            LOAD: begin
               if (bus.in_valid) begin
                  if (beat_reg == BEAT_LAST) begin
                     beat_reg        <= '0;
                     state_reg       <= CLEAR;
                     array_reset_reg <= 1'b0;
                  end else begin
                     beat_reg <= beat_reg + BW'(1);
                  end
               end
            end
            CLEAR: begin
               state_reg <= FEED;
               t_reg     <= '0;
               left_reg  <= left_next;
               top_reg   <= top_next;
            end
            FEED: begin
               if (t_reg == T_LAST) begin
                  state_reg <= DRAIN;
                  drain_reg <= '0;
               end else begin
                  t_reg    <= t_reg + TW'(1);
                  left_reg <= left_next;
                  top_reg  <= top_next;
               end
            end
            DRAIN: begin
               if (drain_reg == D_LAST) begin
                  out_data_reg  <= bus.array_result;
                  out_valid_reg <= 1'b1;
                  state_reg     <= DONE;
               end else begin
                  drain_reg <= drain_reg + DW'(1);
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_reg <= 1'b0;
                  state_reg     <= LOAD;
               end
            end
            default: state_reg <= LOAD;
         endcase
      end
   end

   assign bus.in_ready    = (state_reg == LOAD);
   assign bus.busy        = (state_reg != LOAD);
   assign bus.array_reset = array_reset_reg;
   assign bus.array_left  = left_reg;
   assign bus.array_top   = top_reg;
   assign bus.out_valid   = out_valid_reg;
   assign bus.out_data    = out_data_reg;
endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder with a behavioural output-stationary array model.
module tb_systolic_feeder;
   localparam int WIDTH        = 8;
   localparam int DIM          = 3;
   localparam int DRAIN_CYCLES = 3;
   localparam int VW  = DIM*WIDTH;
   localparam int PW  = 2*WIDTH;
   localparam int RW  = 2*DIM*DIM*WIDTH;
   localparam int LAT = 1 + (3*DIM-2) + DRAIN_CYCLES;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   job_no = 0;

   logic [WIDTH-1:0] ma [DIM][DIM];
   logic [WIDTH-1:0] mb [DIM][DIM];
   logic [PW-1:0]    acc [DIM][DIM];
   logic [VW-1:0]    lh [DIM];
   logic [VW-1:0]    th [DIM];

   systolic_feeder_if #(.WIDTH(WIDTH), .DIM(DIM)) bus ();

   systolic_feeder #(.WIDTH(WIDTH), .DIM(DIM), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] elem(input logic [VW-1:0] v, input int i);
      return v[(DIM-1-i)*WIDTH +: WIDTH];
   endfunction

   function automatic logic [VW-1:0] dl(input int j);
      return (j == 0) ? bus.array_left : lh[j-1];
   endfunction

   function automatic logic [VW-1:0] dt(input int j);
      return (j == 0) ? bus.array_top : th[j-1];
   endfunction

   // Array model: cell (r,c) sees row r delayed by c cycles and column c delayed by r cycles.
   always @(negedge clock) begin
      if (!bus.array_reset) begin
         for (int r = 0; r < DIM; r++) begin
            lh[r] <= '0;
            th[r] <= '0;
            for (int c = 0; c < DIM; c++) acc[r][c] <= '0;
         end
      end else begin
         lh[0] <= bus.array_left;
         th[0] <= bus.array_top;
         for (int i = 1; i < DIM; i++) begin
            lh[i] <= lh[i-1];
            th[i] <= th[i-1];
         end
         for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
               acc[r][c] <= acc[r][c] + PW'(elem(dl(c), r)) * PW'(elem(dt(r), c));
      end
   end

   always_comb begin
      bus.array_result = '0;
      for (int r = 0; r < DIM; r++)
         for (int c = 0; c < DIM; c++)
            bus.array_result[(DIM*DIM-1-(r*DIM+c))*PW +: PW] = acc[r][c];
   end

   function automatic logic [RW-1:0] ref_result();
      logic [RW-1:0] v;
      logic [PW-1:0] s;
      v = '0;
      for (int r = 0; r < DIM; r++)
         for (int c = 0; c < DIM; c++) begin
            s = '0;
            for (int k = 0; k < DIM; k++) s = s + PW'(ma[r][k]) * PW'(mb[k][c]);
            v[(DIM*DIM-1-(r*DIM+c))*PW +: PW] = s;
         end
      return v;
   endfunction

   function automatic logic [VW-1:0] exp_left(input int t);
      logic [VW-1:0] v;
      v = '0;
      for (int r = 0; r < DIM; r++)
         if (t - r >= 0 && t - r < DIM) v[(DIM-1-r)*WIDTH +: WIDTH] = ma[r][t-r];
      return v;
   endfunction

   function automatic logic [VW-1:0] exp_top(input int t);
      logic [VW-1:0] v;
      v = '0;
      for (int c = 0; c < DIM; c++)
         if (t - c >= 0 && t - c < DIM) v[(DIM-1-c)*WIDTH +: WIDTH] = mb[t-c][c];
      return v;
   endfunction

   function automatic logic [VW-1:0] beat_data(input int i);
      logic [VW-1:0] v;
      v = '0;
      for (int k = 0; k < DIM; k++) begin
         if (i < DIM)
            v[(DIM-1-k)*WIDTH +: WIDTH] = ma[i][k];
         else begin
`ifdef SYSTOLIC_FEEDER_B_COLMAJOR_EN
            v[(DIM-1-k)*WIDTH +: WIDTH] = mb[k][i-DIM];
`else
            v[(DIM-1-k)*WIDTH +: WIDTH] = mb[i-DIM][k];
`endif
         end
      end
      return v;
   endfunction

   task automatic fill_identity();
      for (int r = 0; r < DIM; r++)
         for (int c = 0; c < DIM; c++) begin
            ma[r][c] = (r == c) ? WIDTH'(1) : WIDTH'(0);
            mb[r][c] = WIDTH'(r*DIM + c + 1);
         end
   endtask

   task automatic fill_skew();
      for (int r = 0; r < DIM; r++)
         for (int c = 0; c < DIM; c++) begin
            ma[r][c] = WIDTH'(8'h11 * (r + 1));
            mb[r][c] = WIDTH'(c + 1);
         end
   endtask

   task automatic fill_random();
      for (int r = 0; r < DIM; r++)
         for (int c = 0; c < DIM; c++) begin
            ma[r][c] = WIDTH'($urandom);
            mb[r][c] = WIDTH'($urandom);
         end
   endtask

   // stall_mode: 0 none, 1 one idle cycle between beats, 2 random idle gaps.
   task automatic run_job(input int stall_mode, input int bp, input int abort_t);
      int n;
      int k;
      int gap;
      logic [RW-1:0] exp_res;
      exp_res = ref_result();
      job_no++;
      bus.out_ready = (bp == 0);
      for (int i = 0; i < 2*DIM; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = beat_data(i);
         n = 0;
         while (!bus.in_ready && n < 50) begin
            @(negedge clock);
            n++;
         end
         if (n >= 50) begin
            check("in_ready_timeout", RW'(bus.in_ready), RW'(1'b1));
            bus.in_valid = 1'b0;
            return;
         end
         @(negedge clock);
         bus.in_valid = 1'b0;
         bus.in_data  = VW'($urandom);
         if (i < 2*DIM-1) begin
            gap = (stall_mode == 1) ? 1 : (stall_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            repeat (gap) begin
               @(negedge clock);
               check("gap_in_ready", RW'(bus.in_ready), RW'(1'b1));
            end
         end
      end
      k = 0;
      while (!bus.out_valid && k <= LAT + 5) begin
         check($sformatf("array_reset_k%0d", k), RW'(bus.array_reset), RW'(k != 0));
         check($sformatf("left_k%0d", k), RW'(bus.array_left),
               RW'((k >= 1 && k <= 3*DIM-2) ? exp_left(k-1) : VW'(0)));
         check($sformatf("top_k%0d", k), RW'(bus.array_top),
               RW'((k >= 1 && k <= 3*DIM-2) ? exp_top(k-1) : VW'(0)));
         check($sformatf("in_ready_busy_k%0d", k), RW'(bus.in_ready), RW'(1'b0));
         check($sformatf("busy_k%0d", k), RW'(bus.busy), RW'(1'b1));
         if (abort_t >= 0 && k == abort_t + 1) begin
            #2 reset = 1'b0;
            #1;
            check("abort_out_valid", RW'(bus.out_valid), RW'(1'b0));
            check("abort_in_ready", RW'(bus.in_ready), RW'(1'b1));
            check("abort_left", RW'(bus.array_left), RW'(0));
            check("abort_top", RW'(bus.array_top), RW'(0));
            check("abort_busy", RW'(bus.busy), RW'(1'b0));
            check("abort_array_reset", RW'(bus.array_reset), RW'(1'b0));
            check("abort_out_data", bus.out_data, RW'(0));
            @(negedge clock);
            reset = 1'b1;
            $display("job %0d: aborted by reset at feed step %0d", job_no, abort_t);
            return;
         end
         @(negedge clock);
         k++;
      end
      check("latency", RW'(k), RW'(LAT));
      check("out_data", bus.out_data, exp_res);
      $display("job %0d: stall %0d bp %0d latency %0d out_data %0h", job_no, stall_mode, bp, k, bus.out_data);
      repeat (bp) begin
         @(negedge clock);
         check("bp_out_valid", RW'(bus.out_valid), RW'(1'b1));
         check("bp_out_data", bus.out_data, exp_res);
         check("bp_in_ready", RW'(bus.in_ready), RW'(1'b0));
      end
      bus.out_ready = 1'b1;
      @(negedge clock);
      check("post_out_valid", RW'(bus.out_valid), RW'(1'b0));
      check("post_in_ready", RW'(bus.in_ready), RW'(1'b1));
      check("post_out_data_kept", bus.out_data, exp_res);
      bus.out_ready = 1'b0;
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      reset = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_in_ready", RW'(bus.in_ready), RW'(1'b1));
      check("rst_out_valid", RW'(bus.out_valid), RW'(1'b0));
      check("rst_out_data", bus.out_data, RW'(0));
      check("rst_left", RW'(bus.array_left), RW'(0));
      check("rst_top", RW'(bus.array_top), RW'(0));
      check("rst_array_reset", RW'(bus.array_reset), RW'(1'b0));
      check("rst_busy", RW'(bus.busy), RW'(1'b0));
      reset = 1'b1;
      @(negedge clock);
      check("post_rst_array_reset", RW'(bus.array_reset), RW'(1'b1));

      fill_identity();
      run_job(0, 0, -1);
      fill_skew();
      run_job(0, 0, -1);
      fill_random();
      run_job(1, 0, -1);
      fill_random();
      run_job(2, 20, -1);
      fill_random();
      run_job(0, 0, 3);
      fill_random();
      run_job(0, 0, -1);
      for (int j = 0; j < 4; j++) begin
         fill_random();
         run_job(2, int'($urandom_range(0, 3)), -1);
      end
      fill_identity();
      run_job(1, 2, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end
endmodule
